// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding, frame-timing defaults and the mid-bit helper
// shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam int unsigned OVS_DEFAULT    = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Sample count at which the centre of a bit is reached, counting from the
  // tick that detected the start-bit falling edge.
  function automatic int unsigned mid_bit(input int unsigned ovs);
    return ovs / 2 - 1;
  endfunction

  localparam int unsigned MID_BIT_DEFAULT = mid_bit(OVS_DEFAULT);

endpackage

// File: rtl/rx_sync.sv
// rx_sync: two-flop synchronizer for the asynchronous serial line; resets to
// the idle (high) level so a reset never looks like a start bit.
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receiver (start, DATA_W bits LSB first, stop).
// Define UART_RX_PARITY_EN to expect an even parity bit between data and stop.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned OVS    = OVS_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_ENABLE,
  input  logic              Rx_EN,
  input  logic              RxD,
  output logic [DATA_W-1:0] Rx_DATA,
  output logic              Rx_VALID,
  output logic              Rx_PERROR,
  output logic              Rx_FERROR
);

  localparam int unsigned   CW       = $clog2(OVS);
  localparam int unsigned   BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] MID_CNT  = CW'(mid_bit(OVS));
  localparam logic [CW-1:0] LAST_CNT = CW'(OVS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  logic              rxd_s;
  uart_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              stop_fail_q, stop_fail_d;
  logic              ferr_q, ferr_d;
  logic              frame_ok;
`ifdef UART_RX_PARITY_EN
  logic              pfail_q, pfail_d;
  logic              perr_q, perr_d;
`endif

  rx_sync u_rx_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (RxD),
    .q     (rxd_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    stop_fail_d = stop_fail_q;
    ferr_d      = ferr_q;
`ifdef UART_RX_PARITY_EN
    pfail_d     = pfail_q;
    perr_d      = perr_q;
    frame_ok    = !stop_fail_q && !pfail_q;
`else
    frame_ok    = !stop_fail_q;
`endif

    // Results commit one clk after the stop sample, while the FSM is already
    // back in IDLE hunting for the next start bit.
    if (done_q) begin
      ferr_d = stop_fail_q;
`ifdef UART_RX_PARITY_EN
      perr_d = pfail_q;
`endif
      if (frame_ok) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end

    if (!Rx_EN) begin
      state_d = IDLE;
    end else if (sample_ENABLE) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == MID_CNT) begin
            if (!rxd_s) begin
              state_d = DATA;
              cnt_d   = '0;
              bit_d   = '0;
              ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
              perr_d  = 1'b0;
`endif
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            shift_d = {rxd_s, shift_q[DATA_W-1:1]};
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            pfail_d = (^shift_q) ^ rxd_s;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (cnt_q == LAST_CNT) begin
            stop_fail_d = !rxd_s;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      stop_fail_q <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pfail_q     <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      stop_fail_q <= stop_fail_d;
      ferr_q      <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pfail_q     <= pfail_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_FERROR = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign Rx_PERROR = perr_q;
`else
  assign Rx_PERROR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: frame-level bench for uart_receiver (OVS=16, sample_ENABLE
// every 4 clk); honours UART_RX_PARITY_EN when the design is built with it.
module tb_uart_receiver;

  localparam int unsigned DW       = 8;
  localparam int          BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    bit            par_bad;
    bit            stop_bit;
    int            gap;
    bit            exp_valid;
    logic [DW-1:0] exp_data;
    bit            exp_perr;
    bit            exp_ferr;
  } vec_t;

  logic          clk           = 1'b0;
  logic          reset         = 1'b0;
  logic          sample_enable = 1'b0;
  logic          rx_en         = 1'b0;
  logic          rxd           = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_perror;
  logic          rx_ferror;

  int            n_checks  = 0;
  int            n_fail    = 0;
  int            valid_cnt = 0;
  logic [DW-1:0] last_valid_data = '0;
  logic [1:0]    tick_div  = '0;

  logic [DW-1:0] m_data;
  bit            m_perr;
  bit            m_ferr;

  uart_receiver #(.DATA_W(DW), .OVS(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_ENABLE (sample_enable),
    .Rx_EN         (rx_en),
    .RxD           (rxd),
    .Rx_DATA       (rx_data),
    .Rx_VALID      (rx_valid),
    .Rx_PERROR     (rx_perror),
    .Rx_FERROR     (rx_ferror)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      valid_cnt++;
      last_valid_data = rx_data;
    end
    tick_div      = tick_div + 2'd1;
    sample_enable = (tick_div == 2'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Frame-level reference: a frame is accepted only with good parity and stop.
  function automatic int model_frame(input logic [DW-1:0] d, input bit pb, input bit sb);
    if (!pb && sb) begin
      m_data = d;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      return 1;
    end
    m_perr = pb;
    m_ferr = !sb;
    return 0;
  endfunction

  task automatic send_frame(input logic [DW-1:0] data, input bit par_bad, input bit stop_bit,
                            input int abort_pos, input bit abort_rst);
    logic frame[$];
    frame.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) frame.push_back(data[i]);
    if (PAR_EN) frame.push_back((^data) ^ par_bad);
    frame.push_back(stop_bit);
    for (int i = 0; i < frame.size(); i++) begin
      rxd = frame[i];
      if (i == abort_pos) begin
        repeat (BIT_CLKS / 2) @(negedge clk);
        if (abort_rst) begin
          #2 reset = 1'b0;
          #1;
          chk("async_rst_data",   32'(rx_data),   32'd0);
          chk("async_rst_valid",  32'(rx_valid),  32'd0);
          chk("async_rst_perror", 32'(rx_perror), 32'd0);
          chk("async_rst_ferror", 32'(rx_ferror), 32'd0);
        end else begin
          rx_en = 1'b0;
        end
        repeat (BIT_CLKS / 2) @(negedge clk);
      end else begin
        repeat (BIT_CLKS) @(negedge clk);
      end
    end
    rxd = 1'b1;
  endtask

  initial begin
    vec_t          vecs[6];
    int            v0;
    int            ev;
    int            gap;
    logic [DW-1:0] d;
    bit            pb;
    bit            sb;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 100, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 100, !PAR_EN, PAR_EN ? 8'hA5 : 8'h01, PAR_EN, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 100, 1'b0, PAR_EN ? 8'hA5 : 8'h01, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 100, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[4] = '{8'h55, 1'b0, 1'b1, 0,   1'b1, 8'h55, 1'b0, 1'b0};
    vecs[5] = '{8'hAA, 1'b0, 1'b1, 100, 1'b1, 8'hAA, 1'b0, 1'b0};

    rx_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_data",   32'(rx_data),   32'd0);
    chk("reset_valid",  32'(rx_valid),  32'd0);
    chk("reset_perror", 32'(rx_perror), 32'd0);
    chk("reset_ferror", 32'(rx_ferror), 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      send_frame(vecs[i].data, vecs[i].par_bad, vecs[i].stop_bit, -1, 1'b0);
      chk($sformatf("vec%0d_valid_pulses", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_data", i),   32'(rx_data),   32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_perror", i), 32'(rx_perror), 32'(vecs[i].exp_perr));
      chk($sformatf("vec%0d_ferror", i), 32'(rx_ferror), 32'(vecs[i].exp_ferr));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_pulse_data", i), 32'(last_valid_data), 32'(vecs[i].exp_data));
      repeat (vecs[i].gap) @(negedge clk);
    end

    // Low glitch of four sample ticks must be rejected at the mid-start check.
    v0  = valid_cnt;
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (128) @(negedge clk);
    chk("glitch_valid_pulses", 32'(valid_cnt - v0), 32'd0);
    chk("glitch_data",   32'(rx_data),   32'hAA);
    chk("glitch_perror", 32'(rx_perror), 32'd0);
    chk("glitch_ferror", 32'(rx_ferror), 32'd0);

    // Receiver disabled halfway through data bit 3.
    v0 = valid_cnt;
    send_frame(8'hC3, 1'b0, 1'b1, 4, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    rx_en = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    chk("rxen_abort_valid_pulses", 32'(valid_cnt - v0), 32'd0);
    chk("rxen_abort_data",   32'(rx_data),   32'hAA);
    chk("rxen_abort_perror", 32'(rx_perror), 32'd0);
    chk("rxen_abort_ferror", 32'(rx_ferror), 32'd0);

    // Reset asserted halfway through data bit 5, held until the line idles.
    v0 = valid_cnt;
    send_frame(8'h96, 1'b0, 1'b1, 6, 1'b1);
    chk("rst_abort_valid_pulses", 32'(valid_cnt - v0), 32'd0);
    chk("rst_abort_data", 32'(rx_data), 32'd0);
    reset = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);

    v0 = valid_cnt;
    send_frame(8'h5A, 1'b0, 1'b1, -1, 1'b0);
    chk("post_rst_valid_pulses", 32'(valid_cnt - v0), 32'd1);
    chk("post_rst_data", 32'(rx_data), 32'h5A);
    repeat (50) @(negedge clk);

    m_data = 8'h5A;
    m_perr = 1'b0;
    m_ferr = 1'b0;
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      pb  = PAR_EN && ($urandom_range(3) == 0);
      sb  = ($urandom_range(3) != 0);
      // A low stop bit must be followed by idle line or the next start is ambiguous.
      gap = sb ? int'($urandom_range(40)) : 64 + int'($urandom_range(40));
      v0  = valid_cnt;
      ev  = model_frame(d, pb, sb);
      send_frame(d, pb, sb, -1, 1'b0);
      chk($sformatf("rand%0d_valid_pulses", n), 32'(valid_cnt - v0), 32'(ev));
      chk($sformatf("rand%0d_data", n),   32'(rx_data),   32'(m_data));
      chk($sformatf("rand%0d_perror", n), 32'(rx_perror), 32'(m_perr));
      chk($sformatf("rand%0d_ferror", n), 32'(rx_ferror), 32'(m_ferr));
      repeat (gap) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
